// File: rtl/hxmpp_pkg.sv
// Shared readout types and helpers for the HCM/HIM read path.
// Holds the readout state enum, the HIM row width and the slot-extract function.
package hxmpp_pkg;

  localparam int HIT_W     = 32;
  localparam int N_SLOTS   = 4;
  localparam int NCOLS_HIM = HIT_W * N_SLOTS;

  typedef enum logic [2:0] {
    IDLE,
    HCM_RD,
    HCM_WAIT,
    HIM_RD,
    HIM_WAIT,
    STREAM,
    DONE
  } rd_state_t;

  function automatic logic [HIT_W-1:0] slot(input logic [NCOLS_HIM-1:0] row, input int k);
    return row[k*HIT_W +: HIT_W];
  endfunction

endpackage

// File: rtl/hcm_hit_readout_if.sv
// Request, hit-stream and row-status signals of the HCM/HIM readout engine.
// The slave modport is the engine side; master is the requester/consumer side.
interface hcm_hit_readout_if #(
  parameter int ROWINDEXBITS_HCM = 10,
  parameter int HITINFOBITS      = 32,
  parameter int MAXHITNBITS      = 3
);
  logic                        req_valid;
  logic                        req_ready;
  logic [ROWINDEXBITS_HCM-1:0] req_row;
  logic                        hit_valid;
  logic                        hit_ready;
  logic                        hit_last;
  logic [HITINFOBITS-1:0]      hit_info;
  logic                        row_done;
  logic [MAXHITNBITS-1:0]      row_nhits;
  logic                        row_overflow;
  logic                        row_error;

  modport master (
    output req_valid, req_row, hit_ready,
    input  req_ready, hit_valid, hit_info, hit_last,
           row_done, row_nhits, row_overflow, row_error
  );

  modport slave (
    input  req_valid, req_row, hit_ready,
    output req_ready, hit_valid, hit_info, hit_last,
           row_done, row_nhits, row_overflow, row_error
  );
endinterface

// File: rtl/hcm_hit_readout_serializer.sv
// Captures one HIM row and emits its first nbeats slots on a registered valid/ready stream.
// drained pulses combinationally on the handshake of the final beat.
module hit_slot_serializer
  import hxmpp_pkg::*;
#(
  parameter int HITINFOBITS = HIT_W,
  parameter int NSLOTS      = N_SLOTS,
  parameter int MAXHITNBITS = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          load,
  input  logic [MAXHITNBITS-1:0]        nbeats,
  input  logic [HITINFOBITS*NSLOTS-1:0] row_data,
  input  logic                          hit_ready,
  output logic                          hit_valid,
  output logic [HITINFOBITS-1:0]        hit_info,
  output logic                          hit_last,
  output logic                          drained
);

  logic [HITINFOBITS*NSLOTS-1:0] row_q;
  logic [MAXHITNBITS-1:0]        beat;
  logic [MAXHITNBITS-1:0]        nbeats_q;
  logic                          accept;

  assign accept  = hit_valid && hit_ready;
  assign drained = accept && hit_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_q     <= '0;
      beat      <= '0;
      nbeats_q  <= '0;
      hit_valid <= 1'b0;
      hit_info  <= '0;
      hit_last  <= 1'b0;
    end else if (load) begin
      row_q     <= row_data;
      nbeats_q  <= nbeats;
      beat      <= '0;
      hit_valid <= 1'b1;
      hit_info  <= slot(row_data, 0);
      hit_last  <= (nbeats == MAXHITNBITS'(1));
    end else if (accept) begin
      if (hit_last) begin
        hit_valid <= 1'b0;
        hit_last  <= 1'b0;
        hit_info  <= '0;
      end else begin
        // beat still names the slot just accepted; look one ahead for the next one
        beat     <= beat + MAXHITNBITS'(1);
        hit_info <= slot(row_q, int'(beat) + 1);
        hit_last <= (beat + MAXHITNBITS'(2) == nbeats_q);
      end
    end
  end

endmodule

// File: rtl/hcm_hit_readout.sv
// Readout engine: HCM row lookup, HIM row fetch, serialised hit stream.
// Optional HCM read timeout is enabled by defining HCM_READOUT_TIMEOUT_EN.
//
//   state    | meaning
//   IDLE     | req_ready high, waiting for a request
//   HCM_RD   | one-cycle hcm_readRow strobe
//   HCM_WAIT | waiting for hcm_readFinished (optionally bounded)
//   HIM_RD   | one-cycle him_en strobe
//   HIM_WAIT | counting down the BRAM read latency
//   STREAM   | serializer emitting hits
//   DONE     | one-cycle row_done with row status
module hcm_hit_readout
  import hxmpp_pkg::*;
#(
  parameter int ROWINDEXBITS_HCM = 10,
  parameter int ROWINDEXBITS_HIM = 8,
  parameter int HITINFOBITS      = 32,
  parameter int MAXHITNBITS      = 3,
  parameter int NSLOTS           = 4,
  parameter int BRAM_READDELAY   = 2,
  parameter int TIMEOUT          = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  hcm_hit_readout_if.slave              bus,
  output logic                          hcm_readRow,
  output logic [ROWINDEXBITS_HCM-1:0]   hcm_rowToRead,
  input  logic                          hcm_readFinished,
  input  logic [MAXHITNBITS-1:0]        hcm_readNHits,
  input  logic [ROWINDEXBITS_HIM-1:0]   hcm_readHIM_addr,
  output logic                          him_en,
  output logic [ROWINDEXBITS_HIM-1:0]   him_addr,
  input  logic [HITINFOBITS*NSLOTS-1:0] him_data
);

  localparam int WAIT_W = $clog2(BRAM_READDELAY) + 1;

  rd_state_t              state;
  logic [MAXHITNBITS-1:0] nhits_q;
  logic [WAIT_W-1:0]      wait_cnt;
  logic                   load;
  logic                   drained;
  logic [MAXHITNBITS-1:0] nbeats;

  assign load   = (state == HIM_WAIT) && (wait_cnt == '0);
  assign nbeats = (int'(nhits_q) > NSLOTS) ? MAXHITNBITS'(NSLOTS) : nhits_q;

`ifdef HCM_READOUT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT) + 1;
  logic [TO_W-1:0] to_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
  assign bus.row_error = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      nhits_q          <= '0;
      wait_cnt         <= '0;
      bus.req_ready    <= 1'b1;
      hcm_readRow      <= 1'b0;
      hcm_rowToRead    <= '0;
      him_en           <= 1'b0;
      him_addr         <= '0;
      bus.row_done     <= 1'b0;
      bus.row_nhits    <= '0;
      bus.row_overflow <= 1'b0;
`ifdef HCM_READOUT_TIMEOUT_EN
      to_cnt           <= '0;
      bus.row_error    <= 1'b0;
`endif
    end else begin
      hcm_readRow      <= 1'b0;
      him_en           <= 1'b0;
      bus.row_done     <= 1'b0;
      bus.row_nhits    <= '0;
      bus.row_overflow <= 1'b0;
`ifdef HCM_READOUT_TIMEOUT_EN
      bus.row_error    <= 1'b0;
`endif
      case (state)
        IDLE: if (bus.req_valid) begin
          hcm_rowToRead <= bus.req_row;
          hcm_readRow   <= 1'b1;
          bus.req_ready <= 1'b0;
          state         <= HCM_RD;
        end
        HCM_RD: begin
          state <= HCM_WAIT;
`ifdef HCM_READOUT_TIMEOUT_EN
          to_cnt <= TO_W'(TIMEOUT - 1);
`endif
        end
        HCM_WAIT: if (hcm_readFinished) begin
          nhits_q  <= hcm_readNHits;
          him_addr <= hcm_readHIM_addr;
          if (hcm_readNHits == '0) begin
            state        <= DONE;
            bus.row_done <= 1'b1;
          end else begin
            state  <= HIM_RD;
            him_en <= 1'b1;
          end
        end
`ifdef HCM_READOUT_TIMEOUT_EN
        else if (to_cnt == '0) begin
          state         <= DONE;
          nhits_q       <= '0;
          bus.row_done  <= 1'b1;
          bus.row_error <= 1'b1;
        end else begin
          to_cnt <= to_cnt - TO_W'(1);
        end
`endif
        HIM_RD: begin
          wait_cnt <= WAIT_W'(BRAM_READDELAY - 1);
          state    <= HIM_WAIT;
        end
        HIM_WAIT: begin
          if (load) state <= STREAM;
          else      wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        STREAM: if (drained) begin
          state            <= DONE;
          bus.row_done     <= 1'b1;
          bus.row_nhits    <= nhits_q;
          bus.row_overflow <= (int'(nhits_q) > NSLOTS);
        end
        DONE: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  hit_slot_serializer #(
    .HITINFOBITS (HITINFOBITS),
    .NSLOTS      (NSLOTS),
    .MAXHITNBITS (MAXHITNBITS)
  ) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .nbeats    (nbeats),
    .row_data  (him_data),
    .hit_ready (bus.hit_ready),
    .hit_valid (bus.hit_valid),
    .hit_info  (bus.hit_info),
    .hit_last  (bus.hit_last),
    .drained   (drained)
  );

endmodule

// File: tb/tb_hcm_hit_readout.sv
// Bench for hcm_hit_readout: directed table rows, held-request, reset and random rows.
// Define HCM_READOUT_TIMEOUT_EN to also exercise the HCM read timeout (TIMEOUT=8).
`timescale 1ns/1ps
module tb_hcm_hit_readout;
  localparam int RH = 10, RM = 8, HB = 32, MB = 3, NS = 4, BD = 2, TO = 8;
  localparam int NC = HB * NS;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          hcm_readRow;
  logic [RH-1:0] hcm_rowToRead;
  logic          hcm_readFinished;
  logic [MB-1:0] hcm_readNHits;
  logic [RM-1:0] hcm_readHIM_addr;
  logic          him_en;
  logic [RM-1:0] him_addr;
  logic [NC-1:0] him_data;

  hcm_hit_readout_if #(.ROWINDEXBITS_HCM(RH), .HITINFOBITS(HB), .MAXHITNBITS(MB)) bus ();

  hcm_hit_readout #(
    .ROWINDEXBITS_HCM(RH), .ROWINDEXBITS_HIM(RM), .HITINFOBITS(HB), .MAXHITNBITS(MB),
    .NSLOTS(NS), .BRAM_READDELAY(BD), .TIMEOUT(TO)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus),
    .hcm_readRow      (hcm_readRow),
    .hcm_rowToRead    (hcm_rowToRead),
    .hcm_readFinished (hcm_readFinished),
    .hcm_readNHits    (hcm_readNHits),
    .hcm_readHIM_addr (hcm_readHIM_addr),
    .him_en           (him_en),
    .him_addr         (him_addr),
    .him_data         (him_data)
  );

  // HIM BRAM model: data valid BD cycles after him_en, junk pattern otherwise
  logic [NC-1:0] him_mem [256];
  logic [NC-1:0] pipe [BD];
  always @(posedge clk) begin
    pipe[0] <= him_en ? him_mem[him_addr] : {NS{32'hBAD0BAD0}};
    for (int i = 1; i < BD; i++) pipe[i] <= pipe[i-1];
  end
  assign him_data = pipe[BD-1];

  int cyc = 0, nrd = 0, nhs = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (hcm_readRow) nrd <= nrd + 1;
    if (bus.req_valid && bus.req_ready) nhs <= nhs + 1;
  end

  int nvec = 0, nmis = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, 64'({hcm_readRow, him_en, bus.hit_valid, bus.hit_last,
                           bus.row_done, bus.row_overflow, bus.row_error}), 64'd0);
    chk({tag, "_data"}, 64'({hcm_rowToRead, him_addr, bus.row_nhits}), 64'd0);
    chk({tag, "_info"}, 64'(bus.hit_info), 64'd0);
    chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd1);
  endtask

  // One full row; expected hits come from the reference: first exp_beats slots of him_mem[addr]
  task automatic do_row(input logic [RH-1:0] row, input logic [MB-1:0] cnt, input logic [RM-1:0] addr,
                        input int fdly, input int rmode, input bit stray,
                        input int exp_beats, input logic exp_over);
    logic [HB-1:0] expq[$];
    int tf, got, nen, tfirst, pat;
    bit done, busy_rdy, r, pv, pr, plast;
    logic [HB-1:0] pinfo;
    for (int k = 0; k < exp_beats; k++) expq.push_back(him_mem[addr][k*HB +: HB]);
    got = 0; nen = 0; tfirst = -1; pat = 0; done = 0; busy_rdy = 0;
    pv = 0; pr = 0; plast = 0; pinfo = '0;
    @(negedge clk);
    chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1; bus.req_row = row;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("readrow_strobe", 64'(hcm_readRow), 64'd1);
    chk("readrow_row", 64'(hcm_rowToRead), 64'(row));
    @(negedge clk);
    chk("readrow_one_cycle", 64'(hcm_readRow), 64'd0);
    repeat (fdly) @(negedge clk);
    hcm_readFinished = 1'b1; hcm_readNHits = cnt; hcm_readHIM_addr = addr; tf = cyc;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      hcm_readFinished = stray && ($urandom_range(0, 5) == 0);
      hcm_readNHits = '0; hcm_readHIM_addr = RM'($urandom);
      if (him_en) begin
        nen++;
        chk("him_addr", 64'(him_addr), 64'(addr));
        chk("him_en_latency", 64'(cyc - tf), 64'd1);
      end
      if (bus.req_ready) busy_rdy = 1;
      if (pv && !pr) begin
        chk("stall_hold", 64'({bus.hit_valid, bus.hit_last, bus.hit_info}), 64'({1'b1, plast, pinfo}));
      end
      if (bus.hit_valid && tfirst < 0) tfirst = cyc;
      case (rmode)
        0: r = 1'b1;
        1: r = (pat % 4 == 0) || (pat % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      if (bus.hit_valid) pat++;
      bus.hit_ready = r;
      if (bus.hit_valid && r) begin
        if (got < exp_beats) begin
          chk("hit_info", 64'(bus.hit_info), 64'(expq[got]));
          chk("hit_last", 64'(bus.hit_last), 64'(got == exp_beats - 1));
        end else begin
          chk("extra_beat", 64'(got + 1), 64'(exp_beats));
        end
        got++;
      end
      pv = bus.hit_valid; pr = r; plast = bus.hit_last; pinfo = bus.hit_info;
      if (bus.row_done) begin
        done = 1;
        chk("row_nhits", 64'(bus.row_nhits), 64'(cnt));
        chk("row_overflow", 64'(bus.row_overflow), 64'(exp_over));
        chk("row_error", 64'(bus.row_error), 64'd0);
        chk("beats", 64'(got), 64'(exp_beats));
        chk("him_en_count", 64'(nen), 64'(cnt != 0));
        chk("req_ready_busy", 64'(busy_rdy), 64'd0);
        if (cnt == 0) chk("done_latency_zero", 64'(cyc - tf), 64'd1);
        if (rmode == 0 && exp_beats > 0) chk("first_hit_latency", 64'(tfirst - tf), 64'(BD + 2));
      end
    end
    if (!done) chk("row_done_timeout", 64'd0, 64'd1);
    hcm_readFinished = 1'b0;
    bus.hit_ready = 1'b0;
    @(negedge clk);
    chk("back_to_idle", 64'({bus.req_ready, bus.row_done}), 64'({1'b1, 1'b0}));
  endtask

  typedef struct {
    logic [RH-1:0] row;
    logic [MB-1:0] cnt;
    logic [RM-1:0] addr;
    int            fdly;
    int            rmode;
    int            exp_beats;
    logic          exp_over;
  } vec_t;
  vec_t tbl[8];

  initial begin
    int nrd0, nhs0, t0, cnt;
    bit seen, bad;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_row = '0; bus.hit_ready = 1'b0;
    hcm_readFinished = 1'b0; hcm_readNHits = '0; hcm_readHIM_addr = '0;
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < NS; k++) him_mem[a][k*HB +: HB] = $urandom;
    him_mem[8'h12] = {32'hDDDD0004, 32'hCCCC0003, 32'hBBBB0002, 32'hAAAA0001};

    tbl[0] = '{10'd5,  3'd3, 8'h12, 2, 0, 3, 1'b0};
    tbl[1] = '{10'd9,  3'd0, 8'h20, 1, 0, 0, 1'b0};
    tbl[2] = '{10'd33, 3'd6, 8'h30, 0, 0, 4, 1'b1};
    tbl[3] = '{10'd44, 3'd2, 8'h41, 3, 1, 2, 1'b0};
    tbl[4] = '{10'd55, 3'd4, 8'h55, 0, 0, 4, 1'b0};
    tbl[5] = '{10'd66, 3'd1, 8'h66, 4, 2, 1, 1'b0};
    tbl[6] = '{10'd77, 3'd7, 8'h77, 1, 1, 4, 1'b1};
    tbl[7] = '{10'd88, 3'd4, 8'h88, 2, 1, 4, 1'b0};

    repeat (3) @(negedge clk);
    check_idle("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      do_row(tbl[i].row, tbl[i].cnt, tbl[i].addr, tbl[i].fdly, tbl[i].rmode, 1'b0,
             tbl[i].exp_beats, tbl[i].exp_over);

    // req_valid held high over three zero-count rows
    nrd0 = nrd; nhs0 = nhs;
    @(negedge clk);
    bus.req_row = 10'd200; bus.req_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = hcm_readRow;
      end
      chk("held_readrow_seen", 64'(seen), 64'd1);
      chk("held_ready_low", 64'(bus.req_ready), 64'd0);
      if (r == 2) bus.req_valid = 1'b0;
      @(negedge clk);
      hcm_readFinished = 1'b1; hcm_readNHits = '0; hcm_readHIM_addr = '0;
      @(negedge clk);
      hcm_readFinished = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("held_readrow_count", 64'(nrd - nrd0), 64'd3);
    chk("held_handshakes", 64'(nhs - nhs0), 64'd3);

    for (int i = 0; i < 40; i++) begin
      cnt = $urandom_range(0, 7);
      do_row(RH'($urandom), MB'(cnt), RM'($urandom), $urandom_range(0, 5), 2, 1'b1,
             (cnt < NS) ? cnt : NS, 1'(cnt > NS));
    end

    // reset while stalled in STREAM, then a late finished pulse
    bus.hit_ready = 1'b0;
    @(negedge clk); bus.req_valid = 1'b1; bus.req_row = 10'd77;
    @(negedge clk); bus.req_valid = 1'b0;
    @(negedge clk); hcm_readFinished = 1'b1; hcm_readNHits = 3'd4; hcm_readHIM_addr = 8'h12;
    @(negedge clk); hcm_readFinished = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      seen = bus.hit_valid;
    end
    chk("stall_in_stream", 64'(seen), 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    hcm_readFinished = 1'b1; hcm_readNHits = 3'd3; hcm_readHIM_addr = 8'h05;
    @(negedge clk);
    hcm_readFinished = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (him_en || bus.hit_valid || bus.row_done || hcm_readRow || !bus.req_ready) bad = 1;
    end
    chk("late_finished_ignored", 64'(bad), 64'd0);

`ifdef HCM_READOUT_TIMEOUT_EN
    @(negedge clk); bus.req_valid = 1'b1; bus.req_row = 10'd300; t0 = cyc;
    @(negedge clk); bus.req_valid = 1'b0;
    seen = 0; bad = 0;
    for (int c = 0; c < 30 && !seen; c++) begin
      @(negedge clk);
      if (him_en || bus.hit_valid) bad = 1;
      seen = bus.row_done;
    end
    chk("timeout_done_seen", 64'(seen), 64'd1);
    chk("timeout_cycle", 64'(cyc - t0), 64'd10);
    chk("timeout_status", 64'({bus.row_error, bus.row_overflow, bus.row_nhits}), 64'({1'b1, 1'b0, 3'd0}));
    chk("timeout_no_hits", 64'(bad), 64'd0);
`else
    t0 = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
